// File: rtl/result_capture_pkg.sv
// Shared constants and helpers for the result_capture block.
//   DATA_W : width of the CPU RESULT bus
//   cnt_w  : width needed for an occupancy count of 0..depth inclusive
package result_capture_pkg;

  localparam int DATA_W = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with a separate occupancy counter to tell full from empty.
// Ports: clk_i/rst_i (sync, active-high), push_i/pop_i requests, dat_i write data,
//   dat_o head data (0 after reset), full_o/empty_o flags, count_o occupancy.
// A push while full is ignored unless a pop happens in the same cycle; a pop while empty is ignored.
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          push_i,
  input  logic                                          pop_i,
  input  logic [DATA_W-1:0]                             dat_i,
  output logic [DATA_W-1:0]                             dat_o,
  output logic                                          full_o,
  output logic                                          empty_o,
  output logic [result_capture_pkg::cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = result_capture_pkg::cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dat_o   = mem_q[rd_q];

  // Full with a simultaneous pop frees the slot being read, so the push fits.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      // Storage is cleared so the head reads 0 straight after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= dat_i;
    end
  end

endmodule

// File: rtl/result_capture.sv
// Captures changes on the CPU RESULT bus into a small FIFO and streams them out (valid/ready).
// Ports: CLK, RST (sync, active-high), CE sample enable, IN result bus, OUT/OUT_VALID/OUT_READY
//   output stream, COUNT occupancy, OVF sticky drop flag with OVF_CLR, OUT_TS head timestamp.
// Optional macro RESULT_TIMESTAMP_EN: stores a free-running cycle stamp with each entry;
//   without it OUT_TS is tied to 0.
module result_capture
  import result_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic [DATA_W-1:0]         IN,
  output logic [DATA_W-1:0]         OUT,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  output logic                      OVF,
  input  logic                      OVF_CLR,
  output logic [TS_W-1:0]           OUT_TS
);

`ifdef RESULT_TIMESTAMP_EN
  localparam int FIFO_W = DATA_W + TS_W;
`else
  localparam int FIFO_W = DATA_W;
`endif

  logic [DATA_W-1:0] last_q, last_d;
  logic              primed_q, primed_d;
  logic              ovf_q, ovf_d;
  logic              push_req, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_wdat, fifo_rdat;

  // The first enabled sample after reset always counts as a change.
  assign push_req  = CE & (~primed_q | (IN != last_q));
  assign pop       = OUT_VALID & OUT_READY;
  assign drop      = push_req & fifo_full & ~pop;
  assign OUT_VALID = ~fifo_empty;
  assign OVF       = ovf_q;

  always_comb begin
    last_d   = last_q;
    primed_d = primed_q;
    ovf_d    = ovf_q;
    // last follows every enabled sample, including dropped ones, so drops are never retried.
    if (CE) begin
      last_d   = IN;
      primed_d = 1'b1;
    end
    if (drop)         ovf_d = 1'b1;
    else if (OVF_CLR) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q   <= '0;
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      last_q   <= last_d;
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef RESULT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign fifo_wdat = {ts_q, IN};
  assign OUT       = fifo_rdat[DATA_W-1:0];
  assign OUT_TS    = fifo_rdat[FIFO_W-1:DATA_W];
`else
  assign fifo_wdat = IN;
  assign OUT       = fifo_rdat;
  assign OUT_TS    = '0;
`endif

  result_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_req),
    .pop_i   (pop),
    .dat_i   (fifo_wdat),
    .dat_o   (fifo_rdat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (COUNT)
  );

endmodule

// File: tb/tb_result_capture.sv
// Bench for result_capture: reference model + scoreboard queue of expected entries.
// Inputs change and outputs are sampled on the falling edge; DUT samples on the rising edge.
// Builds with or without RESULT_TIMESTAMP_EN.
module tb_result_capture;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b0;
  logic [7:0] IN = 8'h00;
  logic       OUT_READY = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic [7:0] OUT;
  logic       OUT_VALID;
  logic [2:0] COUNT;
  logic       OVF;
  logic [TS_W-1:0] OUT_TS;

  result_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .IN(IN), .OUT(OUT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .COUNT(COUNT), .OVF(OVF), .OVF_CLR(OVF_CLR), .OUT_TS(OUT_TS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]      d;
    logic [TS_W-1:0] ts;
  } ent_t;

  ent_t            sb[$];
  logic [7:0]      last_m;
  bit              primed_m;
  bit              ovf_m;
  logic [TS_W-1:0] ts_m;
  int              total = 0;
  int              bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare DUT state against the model, then drive one cycle of stimulus.
  task automatic step(input bit ce, input logic [7:0] d, input bit rdy, input bit clr);
    bit full_m, pop_m, req_m;
    logic [TS_W-1:0] ts_exp;
    check("count", 32'(COUNT), 32'(sb.size()));
    check("valid", 32'(OUT_VALID), 32'(sb.size() != 0));
    check("ovf", 32'(OVF), 32'(ovf_m));
    if (sb.size() != 0) begin
      check("data", 32'(OUT), 32'(sb[0].d));
`ifdef RESULT_TIMESTAMP_EN
      ts_exp = sb[0].ts;
`else
      ts_exp = '0;
`endif
      check("ts", 32'(OUT_TS), 32'(ts_exp));
    end
    CE = ce; IN = d; OUT_READY = rdy; OVF_CLR = clr;
    full_m = (sb.size() == DEPTH);
    pop_m  = (sb.size() != 0) && rdy;
    req_m  = ce && (!primed_m || d != last_m);
    if (pop_m) void'(sb.pop_front());
    if (req_m) begin
      if (!full_m || pop_m) begin
        ent_t e;
        e.d = d; e.ts = ts_m;
        sb.push_back(e);
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (!(req_m && full_m && !pop_m) && clr) ovf_m = 1'b0;
    if (ce) begin
      last_m = d; primed_m = 1'b1;
    end
    ts_m = ts_m + 1'b1;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reset for one cycle; inputs are held as given while RST is high.
  task automatic do_reset(input bit ce, input logic [7:0] d);
    RST = 1'b1; CE = ce; IN = d; OUT_READY = 1'b0; OVF_CLR = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    last_m = 8'h00; primed_m = 1'b0; ovf_m = 1'b0; ts_m = '0;
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out", 32'(OUT), 32'd0);
    check("rst_ovf", 32'(OVF), 32'd0);
    check("rst_ts", 32'(OUT_TS), 32'd0);
  endtask

  initial begin
    logic [7:0] seq2 [4];
    seq2[0] = 8'h11; seq2[1] = 8'h11; seq2[2] = 8'h22; seq2[3] = 8'h33;
    @(negedge CLK);

    // 1: constant 0x00 -> single entry, no further pushes.
    do_reset(1'b0, 8'h00);
    step(1, 8'h00, 0, 0);
    check("t1_first_vld", 32'(OUT_VALID), 32'd1);
    check("t1_first_out", 32'(OUT), 32'h00);
    repeat (3) step(1, 8'h00, 0, 0);
    check("t1_count", 32'(COUNT), 32'd1);

    // 2: repeats are filtered while the consumer is always ready.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, seq2[i], 1, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    check("t2_ovf", 32'(OVF), 32'd0);
    check("t2_empty", 32'(COUNT), 32'd0);

    // 3: overflow with a blocked consumer, then drain.
    do_reset(1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
    check("t3_count", 32'(COUNT), 32'd4);
    check("t3_ovf", 32'(OVF), 32'd1);
    check("t3_head", 32'(OUT), 32'h01);
    repeat (6) step(0, 8'h05, 1, 0);
    check("t3_drained", 32'(COUNT), 32'd0);

    // 5a: clear with no drop.
    step(0, 8'h05, 0, 1);
    check("t5_clr", 32'(OVF), 32'd0);

    // 4: full FIFO accepts a push when popped in the same cycle.
    for (int i = 6; i <= 9; i++) step(1, 8'(i), 0, 0);
    check("t4_full", 32'(COUNT), 32'd4);
    step(1, 8'h77, 1, 0);
    check("t4_count", 32'(COUNT), 32'd4);
    check("t4_ovf", 32'(OVF), 32'd0);
    repeat (5) step(0, 8'h77, 1, 0);

    // 5b: a drop in the same cycle as the clear keeps OVF set.
    for (int i = 1; i <= 4; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h50, 0, 1);
    check("t5_drop_wins", 32'(OVF), 32'd1);
    step(0, 8'h50, 0, 1);
    check("t5_clr2", 32'(OVF), 32'd0);

    // 6: mid-stream reset discards entries; held value is pushed again.
    do_reset(1'b0, 8'h00);
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    check("t6_pre", 32'(COUNT), 32'd3);
    do_reset(1'b1, 8'h33);
    step(1, 8'h33, 0, 0);
    check("t6_repush_vld", 32'(OUT_VALID), 32'd1);
    check("t6_repush_out", 32'(OUT), 32'h33);
    repeat (2) step(0, 8'h33, 1, 0);

    // 7: timestamps at cycles 3 and 10, then a push after the counter wraps.
    do_reset(1'b0, 8'h00);
    repeat (3) step(0, 8'h00, 0, 0);
    step(1, 8'hA1, 0, 0);
    repeat (6) step(0, 8'hA1, 0, 0);
    step(1, 8'hB2, 0, 0);
`ifdef RESULT_TIMESTAMP_EN
    check("t7_ts3", 32'(OUT_TS), 32'd3);
`endif
    step(0, 8'hB2, 1, 0);
`ifdef RESULT_TIMESTAMP_EN
    check("t7_ts10", 32'(OUT_TS), 32'd10);
`endif
    repeat (250) step(0, 8'hB2, 1, 0);
    step(1, 8'hC3, 0, 0);
    step(0, 8'hC3, 1, 0);

    // Random traffic.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    repeat (6) step(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
